bus_trace_buffer: RTL and testbench

Synthesizable circular trace buffer that snoops the 6502 CPU bus (A_BUS, D_BUS, RW, SYNC) and records qualified bus cycles around a programmable address trigger. It sits beside the CPU and program ROM on the shared bus and replaces fixed-window simulation waveform inspection with an on-chip, parametrised capture that software or a bench can read back after the trigger.

---
 rtl/bus_trace_buffer.sv | 144 ++++++++++++++
 tb/tb_bus_trace_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_trace_buffer.sv
// Circular trace buffer that snoops the 6502 bus and freezes a window of
// qualified bus cycles around a masked, SYNC-qualified address trigger.
module bus_trace_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [ADDR_W-1:0]        A_BUS,
    input  logic [DATA_W-1:0]        D_BUS,
    input  logic                     RW,
    input  logic                     SYNC,
    input  logic                     sample_en,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [ADDR_W-1:0]        trig_mask,
    input  logic [PTR_W-1:0]         post_count,
    input  logic                     rd_en,
    output logic [ADDR_W+DATA_W+1:0] rd_data,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic [PTR_W:0]           count,
    output logic [PTR_W-1:0]         trig_pos
);

    localparam int ENTRY_W = ADDR_W + DATA_W + 2;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e              r_state;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [PTR_W-1:0]    r_remain;
    logic [PTR_W-1:0]    r_post;
    logic [PTR_W-1:0]    r_trig_pos;
    logic [ENTRY_W-1:0]  r_rd_data;
    logic                r_rd_valid;

    logic                w_hit;
    logic                w_cap;
    logic                w_done_now;
    logic [PTR_W-1:0]    w_wr_ptr_inc;
    logic [PTR_W:0]      w_count_inc;
    logic [PTR_W-1:0]    w_oldest;
    logic [PTR_W-1:0]    w_trig_pos;

    assign w_hit = SYNC && (((A_BUS ^ trig_addr) & trig_mask) == '0);

    // arm/disarm take priority, so a coincident sample is dropped
    assign w_cap = sample_en && !arm && !disarm &&
                   ((r_state == StArmed) || (r_state == StPost));

    assign w_done_now = w_cap &&
                        (((r_state == StArmed) && w_hit && (r_remain == '0)) ||
                         ((r_state == StPost) && (r_remain == PTR_ONE)));

    assign w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
    assign w_count_inc  = (r_count == CNT_FULL) ? r_count : r_count + CNT_ONE;

    // Once wrapped, the oldest entry sits at the slot about to be overwritten
    assign w_oldest   = (w_count_inc == CNT_FULL) ? w_wr_ptr_inc : '0;
    assign w_trig_pos = w_count_inc[PTR_W-1:0] - PTR_ONE - r_post;

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem[r_wr_ptr] <= {RW, SYNC, A_BUS, D_BUS};
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state    <= StIdle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_remain   <= '0;
            r_post     <= '0;
            r_trig_pos <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (arm) begin
                r_state  <= StArmed;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_remain <= post_count;
                r_post   <= post_count;
            end else if (disarm && (r_state != StIdle)) begin
                r_state <= StIdle;
                r_count <= '0;
            end else begin
                case (r_state)
                    StArmed, StPost: begin
                        if (sample_en) begin
                            r_wr_ptr <= w_wr_ptr_inc;
                            r_count  <= w_count_inc;
                            if (r_state == StPost) begin
                                r_remain <= r_remain - PTR_ONE;
                            end
                            if (w_done_now) begin
                                r_state    <= StDone;
                                r_trig_pos <= w_trig_pos;
                                r_rd_ptr   <= w_oldest;
                            end else if ((r_state == StArmed) && w_hit) begin
                                r_state <= StPost;
                            end
                        end
                    end
                    StDone: begin
                        if (rd_en && (r_count != '0)) begin
                            r_rd_data  <= r_mem[r_rd_ptr];
                            r_rd_valid <= 1'b1;
                            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                            r_count    <= r_count - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign count    = r_count;
    assign trig_pos = r_trig_pos;

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Self-checking bench for bus_trace_buffer: a fixed vector table, directed
// corner sequences and a randomized run against a queue-based reference.
module tb_bus_trace_buffer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] A_BUS = '0;
    logic [7:0]  D_BUS = '0;
    logic        RW = 1'b0;
    logic        SYNC = 1'b0;
    logic        sample_en = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic [15:0] trig_addr = '0;
    logic [15:0] trig_mask = '0;
    logic [5:0]  post_count = '0;
    logic        rd_en = 1'b0;
    logic [25:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;
    logic [6:0]  count;
    logic [5:0]  trig_pos;

    bus_trace_buffer #(
        .ADDR_W(16),
        .DATA_W(8),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .A_BUS     (A_BUS),
        .D_BUS     (D_BUS),
        .RW        (RW),
        .SYNC      (SYNC),
        .sample_en (sample_en),
        .arm       (arm),
        .disarm    (disarm),
        .trig_addr (trig_addr),
        .trig_mask (trig_mask),
        .post_count(post_count),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .state     (state),
        .count     (count),
        .trig_pos  (trig_pos)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: the list of recorded entries, trimmed to DEPTH.
    logic [25:0] m_q[$];
    int          m_st;
    int          m_rem;
    int          m_pc;
    int          m_tp;
    logic [25:0] m_last;

    task automatic do_reset();
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        m_q.delete();
        m_st   = 0;
        m_rem  = 0;
        m_pc   = 0;
        m_tp   = 0;
        m_last = '0;
    endtask

    task automatic cycle(input logic se, input logic ar, input logic dis, input logic rd,
                         input logic [15:0] a, input logic sy);
        logic [25:0] e;
        logic        hit;
        logic        ev;
        sample_en = se;
        arm       = ar;
        disarm    = dis;
        rd_en     = rd;
        A_BUS     = a;
        D_BUS     = a[7:0] ^ 8'h5A;
        RW        = a[0];
        SYNC      = sy;
        e   = {a[0], sy, a, a[7:0] ^ 8'h5A};
        hit = sy && (((a ^ trig_addr) & trig_mask) == 16'h0);
        ev  = 1'b0;
        if (ar) begin
            m_st = 1;
            m_q.delete();
            m_pc  = int'(post_count);
            m_rem = int'(post_count);
        end else if (dis && m_st != 0) begin
            m_st = 0;
            m_q.delete();
        end else if ((m_st == 1 || m_st == 2) && se) begin
            m_q.push_back(e);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (m_st == 1) begin
                if (hit) begin
                    if (m_rem == 0) begin
                        m_st = 3;
                        m_tp = m_q.size() - 1 - m_pc;
                    end else m_st = 2;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_st = 3;
                    m_tp = m_q.size() - 1 - m_pc;
                end
            end
        end else if (m_st == 3 && rd && m_q.size() > 0) begin
            m_last = m_q.pop_front();
            ev = 1'b1;
        end
        @(posedge clk); #1;
        sample_en = 1'b0;
        arm       = 1'b0;
        disarm    = 1'b0;
        rd_en     = 1'b0;
        chk("state", 64'(state), 64'(m_st));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("rd_valid", 64'(rd_valid), 64'(ev));
        chk("rd_data", 64'(rd_data), 64'(m_last));
        if (m_st == 3) chk("trig_pos", 64'(trig_pos), 64'(m_tp));
    endtask

    typedef struct {
        logic        se;
        logic        ar;
        logic        rd;
        logic [15:0] a;
        logic [1:0]  st;
        logic [6:0]  cnt;
        logic        vld;
        logic [15:0] ra;
    } vec_t;

    function automatic vec_t mk(input logic se, input logic ar, input logic rd,
                                input logic [15:0] a, input logic [1:0] st,
                                input logic [6:0] cnt, input logic vld,
                                input logic [15:0] ra);
        vec_t v;
        v.se = se; v.ar = ar; v.rd = rd; v.a = a;
        v.st = st; v.cnt = cnt; v.vld = vld; v.ra = ra;
        return v;
    endfunction

    vec_t tab[20];

    initial begin
        logic [1:0] st_e;
        // Capture 0x8000.. with trigger at 0x8004, three post samples, then drain
        tab[0] = mk(1'b0, 1'b1, 1'b0, 16'h0, 2'd1, 7'd0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            st_e = (i < 4) ? 2'd1 : ((i < 7) ? 2'd2 : 2'd3);
            tab[1+i] = mk(1'b1, 1'b0, 1'b0, 16'(16'h8000 + i), st_e, 7'(i + 1), 1'b0, 16'h0);
        end
        tab[9]  = mk(1'b1, 1'b0, 1'b0, 16'h8008, 2'd3, 7'd8, 1'b0, 16'h0);
        tab[10] = mk(1'b1, 1'b0, 1'b0, 16'h8009, 2'd3, 7'd8, 1'b0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            tab[11+k] = mk(1'b0, 1'b0, 1'b1, 16'h0, 2'd3, 7'(7 - k), 1'b1, 16'(16'h8000 + k));
        end
        tab[19] = mk(1'b0, 1'b0, 1'b1, 16'h0, 2'd3, 7'd0, 1'b0, 16'h0);

        RST = 1'b1;
        @(posedge clk); #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_trig_pos", 64'(trig_pos), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        do_reset();

        trig_addr  = 16'h8004;
        trig_mask  = 16'hFFFF;
        post_count = 6'd3;
        for (int i = 0; i < 20; i++) begin
            sample_en = tab[i].se;
            arm       = tab[i].ar;
            rd_en     = tab[i].rd;
            A_BUS     = tab[i].a;
            D_BUS     = tab[i].a[7:0];
            RW        = 1'b1;
            SYNC      = 1'b1;
            @(posedge clk); #1;
            sample_en = 1'b0;
            arm       = 1'b0;
            rd_en     = 1'b0;
            chk($sformatf("tab%0d_state", i), 64'(state), 64'(tab[i].st));
            chk($sformatf("tab%0d_count", i), 64'(count), 64'(tab[i].cnt));
            chk($sformatf("tab%0d_rd_valid", i), 64'(rd_valid), 64'(tab[i].vld));
            if (tab[i].vld)
                chk($sformatf("tab%0d_rd_data", i), 64'(rd_data),
                    64'({1'b1, 1'b1, tab[i].ra, tab[i].ra[7:0]}));
            if (i == 10) chk("tab_trig_pos", 64'(trig_pos), 64'd4);
        end

        // Wrap: 100 pre-trigger samples, trigger at 0x0064, no post samples
        do_reset();
        trig_addr  = 16'h0064;
        trig_mask  = 16'hFFFF;
        post_count = 6'd0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i <= 100; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 1'b1);
        chk("wrap_count", 64'(count), 64'd64);
        chk("wrap_trig_pos", 64'(trig_pos), 64'd63);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        chk("wrap_first_addr", 64'(rd_data[23:8]), 64'h0025);
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);

        // Masked trigger must also require SYNC
        do_reset();
        trig_addr  = 16'h80AA;
        trig_mask  = 16'hFF00;
        post_count = 6'd0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h8012, 1'b0);
        chk("mask_nosync_state", 64'(state), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h8012, 1'b1);
        chk("mask_sync_state", 64'(state), 64'd3);

        // Qualifier low on alternate cycles
        do_reset();
        trig_addr  = 16'h4000;
        trig_mask  = 16'hFFFF;
        post_count = 6'd5;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++)
            cycle((i % 2) == 0, 1'b0, 1'b0, 1'b0, 16'(16'h3000 + i), 1'b1);
        chk("qual_count", 64'(count), 64'd6);

        // disarm in POST, then arm+disarm together
        do_reset();
        trig_addr  = 16'h0002;
        post_count = 6'd10;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 1'b1);
        chk("post_state", 64'(state), 64'd2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("disarm_state", 64'(state), 64'd0);
        chk("disarm_count", 64'(count), 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1);
        chk("arm_wins_state", 64'(state), 64'd1);
        chk("arm_drops_sample", 64'(count), 64'd0);

        // Asynchronous reset in the middle of readout
        do_reset();
        trig_addr  = 16'h0001;
        post_count = 6'd2;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'(i), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
        RST = 1'b1;
        #2;
        chk("rst_mid_state", 64'(state), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_mid_rd_data", 64'(rd_data), 64'd0);
        chk("rst_mid_trig_pos", 64'(trig_pos), 64'd0);
        do_reset();

        // Randomized traffic against the model
        trig_addr = 16'h1230;
        trig_mask = 16'hFFF0;
        for (int n = 0; n < 3000; n++) begin
            logic ar;
            ar = (n == 0) || ($urandom_range(0, 49) == 0);
            if (ar) post_count = 6'($urandom_range(0, 63));
            cycle($urandom_range(0, 3) != 0, ar, $urandom_range(0, 79) == 0,
                  1'($urandom_range(0, 1)), 16'h1200 | 16'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
